alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter ALU_LAT, default 1, clock edges from alu_in1/alu_in2/alu_op applied to alu_result/alu_status valid (legal 0..7).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 reqN_valid  input  1  requester N (N=0,1) has an operation pending.
REQ-005 reqN_ready  output  1  requester N's operation accepted this cycle.
REQ-006 reqN_in1, reqN_in2  input  32 each  operands of requester N.
REQ-007 reqN_op  input  4  opcode of requester N.
REQ-008 rspN_valid  output  1  one-cycle pulse: response for requester N.
REQ-009 rspN_result  output  32; rspN_status  output  5; rspN_err  output  1  (illegal opcode).
REQ-010 alu_in1, alu_in2  output  32 each; alu_op  output  4  drive shared ALU.
REQ-011 alu_result  input  32; alu_status  input  5  from shared ALU.
REQ-012 busy  output  1  high in any state other than IDLE.

Function
REQ-013 States: IDLE, EXEC, RESP; one operation in flight at a time.
REQ-014 reqN_ready combinational, high only in IDLE for the granted valid requester; at most one ready high per cycle.
REQ-015 Transfer occurs when reqN_valid and reqN_ready both high; operands, op and owner ID captured that edge.
REQ-016 Arbitration: single valid requester wins; both valid -> requester not granted most recently wins (round-robin); last_grant updates only on transfer.
REQ-017 Legal opcodes 0..11; after legal transfer in cycle T, state EXEC cycles T+1..T+1+ALU_LAT, alu_* driven from captured regs throughout.
REQ-018 alu_result/alu_status sampled at end of last EXEC cycle into owner's response regs; RESP in cycle T+2+ALU_LAT; IDLE next cycle.
REQ-019 Opcodes 12..15: accepted normally, no ALU issue (alu_* stay 0), RESP in T+1 with result 0, status 0, err 1.
REQ-020 rspN_valid high only in RESP and only for owner; rspN_result/status/err hold last value until next response to N.
REQ-021 Outside EXEC, alu_in1, alu_in2, alu_op driven 0.
REQ-022 Requester withdrawing valid before transfer: no effect; valid during EXEC/RESP ignored (ready low).
REQ-023 Earliest next accept: IDLE cycle after RESP; back-to-back period ALU_LAT+3 cycles.

Reset
REQ-024 rst high at any edge: state IDLE, last_grant=1 (req0 wins first tie), all outputs 0, captured regs 0.
REQ-025 Reset mid-EXEC/RESP discards in-flight operation; no response pulse emitted.

Structure
REQ-026 Shared package alu_ctrl_pkg: DATA_W=32, OP_W=4, STAT_W=5, OP_MAX=11, state enum.
REQ-027 One sub-module rr_arb2: 2-way round-robin grant with last_grant register; FSM, capture regs, latency counter in alu_arbiter.

Verification (bench ALU stub: op 1 returns in1+in2, status 0, with ALU_LAT latency)
REQ-028 ALU_LAT=1, req0 op1 in1=5 in2=6 at T -> req0_ready T, rsp0_valid T+3, rsp0_result=11, err 0.
REQ-029 Both valid continuously, op1 -> grants alternate 0,1,0,1; accepts 4 cycles apart; rsp owner matches grant.
REQ-030 req1 op 4'd13 -> rsp1_valid T+1, result 0, status 0, err 1; alu_op stays 0.
REQ-031 rst pulsed in EXEC -> no rspN_valid; busy 0 next cycle; next tie grants req0.
REQ-032 ALU_LAT=0 and ALU_LAT=3, in1=32'hFFFF_FFFF in2=1 op1 -> rsp at T+2 / T+5, result 0.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the ALU arbiter slice.
package alu_ctrl_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned STAT_W = 5;
  localparam int unsigned OP_MAX = 11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Opcodes above OP_MAX are accepted but never issued to the ALU.
  function automatic logic op_legal(input logic [OP_W-1:0] op);
    return op <= OP_W'(OP_MAX);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant. A grant is only produced while enabled, and a
// grant always coincides with a transfer, so last_grant tracks transfers.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic last_grant_q;
  logic last_grant_d;

  // Grant selection and last-grant update.
  always_comb begin
    gnt          = '0;
    last_grant_d = last_grant_q;
    if (en) begin
      if (req[0] && req[1]) begin
        gnt = last_grant_q ? 2'b01 : 2'b10;
      end else begin
        gnt = req;
      end
    end
    if (gnt[1]) begin
      last_grant_d = 1'b1;
    end else if (gnt[0]) begin
      last_grant_d = 1'b0;
    end
  end

  // Reset to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two requesters onto one shared, fixed-latency ALU with one
// operation in flight at a time.
module alu_arbiter
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned ALU_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [DATA_W-1:0]   req0_in1,
  input  logic [DATA_W-1:0]   req0_in2,
  input  logic [OP_W-1:0]     req0_op,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [DATA_W-1:0]   req1_in1,
  input  logic [DATA_W-1:0]   req1_in2,
  input  logic [OP_W-1:0]     req1_op,
  output logic                rsp0_valid,
  output logic [DATA_W-1:0]   rsp0_result,
  output logic [STAT_W-1:0]   rsp0_status,
  output logic                rsp0_err,
  output logic                rsp1_valid,
  output logic [DATA_W-1:0]   rsp1_result,
  output logic [STAT_W-1:0]   rsp1_status,
  output logic                rsp1_err,
  output logic [DATA_W-1:0]   alu_in1,
  output logic [DATA_W-1:0]   alu_in2,
  output logic [OP_W-1:0]     alu_op,
  input  logic [DATA_W-1:0]   alu_result,
  input  logic [STAT_W-1:0]   alu_status,
  output logic                busy
);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   in1_q, in1_d;
  logic [DATA_W-1:0]   in2_q, in2_d;
  logic [OP_W-1:0]     op_q, op_d;
  logic                owner_q, owner_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [DATA_W-1:0]   res0_q, res0_d, res1_q, res1_d;
  logic [STAT_W-1:0]   st0_q, st0_d, st1_q, st1_d;
  logic                err0_q, err0_d, err1_q, err1_d;

  logic [1:0]          gnt;
  logic [DATA_W-1:0]   sel_in1, sel_in2;
  logic [OP_W-1:0]     sel_op;

  rr_arb2 u_rr_arb2 (
    .clk (clk),
    .rst (rst),
    .en  (state_q == ST_IDLE),
    .req ({req1_valid, req0_valid}),
    .gnt (gnt)
  );

  assign sel_in1 = gnt[1] ? req1_in1 : req0_in1;
  assign sel_in2 = gnt[1] ? req1_in2 : req0_in2;
  assign sel_op  = gnt[1] ? req1_op  : req0_op;

  // Next state, operand capture, latency count and response registers.
  always_comb begin
    state_d = state_q;
    in1_d   = in1_q;
    in2_d   = in2_q;
    op_d    = op_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    res0_d  = res0_q;
    st0_d   = st0_q;
    err0_d  = err0_q;
    res1_d  = res1_q;
    st1_d   = st1_q;
    err1_d  = err1_q;
    case (state_q)
      ST_IDLE: begin
        if (|gnt) begin
          in1_d   = sel_in1;
          in2_d   = sel_in2;
          op_d    = sel_op;
          owner_d = gnt[1];
          cnt_d   = '0;
          if (op_legal(sel_op)) begin
            state_d = ST_EXEC;
          end else begin
            // Illegal op skips EXEC; its response is ready for the next cycle.
            state_d = ST_RESP;
            if (gnt[1]) begin
              res1_d = '0;
              st1_d  = '0;
              err1_d = 1'b1;
            end else begin
              res0_d = '0;
              st0_d  = '0;
              err0_d = 1'b1;
            end
          end
        end
      end
      ST_EXEC: begin
        if (cnt_q == 3'(ALU_LAT)) begin
          state_d = ST_RESP;
          if (owner_q) begin
            res1_d = alu_result;
            st1_d  = alu_status;
            err1_d = 1'b0;
          end else begin
            res0_d = alu_result;
            st0_d  = alu_status;
            err0_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      in1_q   <= '0;
      in2_q   <= '0;
      op_q    <= '0;
      owner_q <= 1'b0;
      cnt_q   <= '0;
      res0_q  <= '0;
      st0_q   <= '0;
      err0_q  <= 1'b0;
      res1_q  <= '0;
      st1_q   <= '0;
      err1_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      in1_q   <= in1_d;
      in2_q   <= in2_d;
      op_q    <= op_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      res0_q  <= res0_d;
      st0_q   <= st0_d;
      err0_q  <= err0_d;
      res1_q  <= res1_d;
      st1_q   <= st1_d;
      err1_q  <= err1_d;
    end
  end

  assign req0_ready  = gnt[0];
  assign req1_ready  = gnt[1];
  assign busy        = (state_q != ST_IDLE);
  assign rsp0_valid  = (state_q == ST_RESP) && !owner_q;
  assign rsp1_valid  = (state_q == ST_RESP) && owner_q;
  assign rsp0_result = res0_q;
  assign rsp0_status = st0_q;
  assign rsp0_err    = err0_q;
  assign rsp1_result = res1_q;
  assign rsp1_status = st1_q;
  assign rsp1_err    = err1_q;
  assign alu_in1     = (state_q == ST_EXEC) ? in1_q : '0;
  assign alu_in2     = (state_q == ST_EXEC) ? in2_q : '0;
  assign alu_op      = (state_q == ST_EXEC) ? op_q  : '0;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: three instances (ALU_LAT 1, 0, 3) share stimulus,
// each with its own ALU stub and transaction-level reference model.
module tb_alu_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req0_valid, req1_valid;
  logic [31:0] req0_in1, req0_in2, req1_in1, req1_in2;
  logic [3:0]  req0_op, req1_op;

  logic        rdy0_o[3], rdy1_o[3], rv0_o[3], rv1_o[3];
  logic        err0_o[3], err1_o[3], busy_o[3];
  logic [31:0] res0_o[3], res1_o[3], ai1[3], ai2[3], ares[3];
  logic [4:0]  st0_o[3], st1_o[3], ast[3];
  logic [3:0]  aop[3];

  int n_checks = 0;
  int n_pass   = 0;

  function automatic int unsigned lat_of(input int i);
    return (i == 0) ? 1 : (i == 1) ? 0 : 3;
  endfunction

  // ALU stub: op 1 adds with status 0; other ops give a distinct pattern.
  function automatic logic [36:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] op);
    if (op == 4'd1) return {5'd0, a + b};
    return {1'b0, op, a ^ b};
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned L = (g == 0) ? 1 : (g == 1) ? 0 : 3;
    logic [36:0] pipe [8];

    alu_arbiter #(.ALU_LAT(L)) u_dut (
      .clk         (clk),
      .rst         (rst),
      .req0_valid  (req0_valid),
      .req0_ready  (rdy0_o[g]),
      .req0_in1    (req0_in1),
      .req0_in2    (req0_in2),
      .req0_op     (req0_op),
      .req1_valid  (req1_valid),
      .req1_ready  (rdy1_o[g]),
      .req1_in1    (req1_in1),
      .req1_in2    (req1_in2),
      .req1_op     (req1_op),
      .rsp0_valid  (rv0_o[g]),
      .rsp0_result (res0_o[g]),
      .rsp0_status (st0_o[g]),
      .rsp0_err    (err0_o[g]),
      .rsp1_valid  (rv1_o[g]),
      .rsp1_result (res1_o[g]),
      .rsp1_status (st1_o[g]),
      .rsp1_err    (err1_o[g]),
      .alu_in1     (ai1[g]),
      .alu_in2     (ai2[g]),
      .alu_op      (aop[g]),
      .alu_result  (ares[g]),
      .alu_status  (ast[g]),
      .busy        (busy_o[g])
    );

    always_ff @(posedge clk) begin
      pipe[0] <= alu_ref(ai1[g], ai2[g], aop[g]);
      for (int k = 1; k < 8; k++) pipe[k] <= pipe[k-1];
    end

    if (L == 0) begin : g_comb
      assign {ast[g], ares[g]} = alu_ref(ai1[g], ai2[g], aop[g]);
    end else begin : g_pipe
      assign {ast[g], ares[g]} = pipe[L-1];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference model: per-transaction bookkeeping in absolute cycle numbers.
  int          cyc;
  int          free_at[3], resp_at[3], exec_lo[3], exec_hi[3], gexp[3];
  logic        own[3], lastg[3];
  logic [31:0] c1[3], c2[3], pres[3];
  logic [3:0]  cop[3];
  logic [4:0]  pst[3];
  logic        perr[3];
  logic [31:0] hres[3][2];
  logic [4:0]  hst[3][2];
  logic        herr[3][2];

  task automatic model_reset(input int i, input int idle_from);
    free_at[i] = idle_from;
    resp_at[i] = -1;
    exec_lo[i] = 0;
    exec_hi[i] = -1;
    lastg[i]   = 1'b1;
    own[i]     = 1'b0;
    c1[i] = '0; c2[i] = '0; cop[i] = '0;
    for (int n = 0; n < 2; n++) begin
      hres[i][n] = '0; hst[i][n] = '0; herr[i][n] = 1'b0;
    end
  endtask

  task automatic check_inst(input int i);
    string p;
    logic  idle, in_exec;
    p = $sformatf("L%0d_", lat_of(i));
    if (cyc == resp_at[i]) begin
      hres[i][own[i]] = pres[i];
      hst[i][own[i]]  = pst[i];
      herr[i][own[i]] = perr[i];
    end
    idle    = (cyc >= free_at[i]);
    in_exec = (cyc >= exec_lo[i]) && (cyc <= exec_hi[i]);
    gexp[i] = -1;
    if (idle) begin
      if (req0_valid && req1_valid) gexp[i] = lastg[i] ? 0 : 1;
      else if (req0_valid)          gexp[i] = 0;
      else if (req1_valid)          gexp[i] = 1;
    end
    check({p, "rdy0"}, rdy0_o[i], gexp[i] == 0);
    check({p, "rdy1"}, rdy1_o[i], gexp[i] == 1);
    check({p, "busy"}, busy_o[i], !idle);
    check({p, "rsp0_valid"}, rv0_o[i], (cyc == resp_at[i]) && !own[i]);
    check({p, "rsp1_valid"}, rv1_o[i], (cyc == resp_at[i]) && own[i]);
    check({p, "rsp0_result"}, res0_o[i], hres[i][0]);
    check({p, "rsp0_status"}, st0_o[i], hst[i][0]);
    check({p, "rsp0_err"}, err0_o[i], herr[i][0]);
    check({p, "rsp1_result"}, res1_o[i], hres[i][1]);
    check({p, "rsp1_status"}, st1_o[i], hst[i][1]);
    check({p, "rsp1_err"}, err1_o[i], herr[i][1]);
    check({p, "alu_in1"}, ai1[i], in_exec ? c1[i] : 32'd0);
    check({p, "alu_in2"}, ai2[i], in_exec ? c2[i] : 32'd0);
    check({p, "alu_op"}, aop[i], in_exec ? cop[i] : 4'd0);
  endtask

  task automatic advance(input int i);
    int unsigned l;
    l = lat_of(i);
    if (rst) begin
      model_reset(i, cyc + 1);
    end else if (gexp[i] >= 0) begin
      own[i]   = (gexp[i] == 1);
      lastg[i] = own[i];
      c1[i]    = own[i] ? req1_in1 : req0_in1;
      c2[i]    = own[i] ? req1_in2 : req0_in2;
      cop[i]   = own[i] ? req1_op  : req0_op;
      if (cop[i] <= 4'd11) begin
        exec_lo[i] = cyc + 1;
        exec_hi[i] = cyc + 1 + int'(l);
        resp_at[i] = cyc + 2 + int'(l);
        {pst[i], pres[i]} = alu_ref(c1[i], c2[i], cop[i]);
        perr[i] = 1'b0;
      end else begin
        exec_lo[i] = 0;
        exec_hi[i] = -1;
        resp_at[i] = cyc + 1;
        pres[i] = '0; pst[i] = '0; perr[i] = 1'b1;
      end
      free_at[i] = resp_at[i] + 1;
    end
  endtask

  // One clock cycle: drive after the falling edge, check, then update the model.
  task automatic step(input logic r, input logic v0, input logic v1,
                      input logic [3:0] o0, input logic [3:0] o1,
                      input logic [31:0] x0, input logic [31:0] y0,
                      input logic [31:0] x1, input logic [31:0] y1);
    @(negedge clk);
    rst = r; req0_valid = v0; req1_valid = v1;
    req0_op = o0; req1_op = o1;
    req0_in1 = x0; req0_in2 = y0; req1_in1 = x1; req1_in2 = y1;
    #1;
    for (int i = 0; i < 3; i++) check_inst(i);
    for (int i = 0; i < 3; i++) advance(i);
    cyc++;
  endtask

  task automatic idle_steps(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, '0, '0, '0, '0);
  endtask

  function automatic logic [3:0] rand_op();
    int unsigned r;
    r = $urandom_range(0, 3);
    if (r <= 1) return 4'd1;
    if (r == 2) return 4'($urandom_range(0, 11));
    return 4'($urandom_range(12, 15));
  endfunction

  int gcyc[$];
  int gown[$];

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_op = '0; req1_op = '0;
    req0_in1 = '0; req0_in2 = '0; req1_in1 = '0; req1_in2 = '0;
    cyc = 0;
    for (int i = 0; i < 3; i++) begin
      model_reset(i, 0);
      gexp[i] = -1; pres[i] = '0; pst[i] = '0; perr[i] = 1'b0;
    end
    repeat (2) @(posedge clk);

    // Reset state, checked with reset still asserted and then released.
    step(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, '0, '0, '0, '0);
    idle_steps(2);

    // Single add 5+6 from req0.
    step(1'b0, 1'b1, 1'b0, 4'd1, 4'd0, 32'd5, 32'd6, '0, '0);
    check("r028_ready", rdy0_o[0], 1);
    for (int k = 1; k <= 6; k++) begin
      step(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, '0, '0, '0, '0);
      if (k == 3) begin
        check("r028_rsp_valid", rv0_o[0], 1);
        check("r028_result", res0_o[0], 32'd11);
        check("r028_err", err0_o[0], 0);
      end
    end

    // Wrap-around add at latency 0 and 3.
    step(1'b0, 1'b1, 1'b0, 4'd1, 4'd0, 32'hFFFF_FFFF, 32'd1, '0, '0);
    for (int k = 1; k <= 7; k++) begin
      step(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, '0, '0, '0, '0);
      if (k == 2) begin
        check("r032_l0_valid", rv0_o[1], 1);
        check("r032_l0_result", res0_o[1], 32'd0);
      end
      if (k == 5) begin
        check("r032_l3_valid", rv0_o[2], 1);
        check("r032_l3_result", res0_o[2], 32'd0);
      end
    end

    // Illegal opcode from req1.
    step(1'b0, 1'b0, 1'b1, 4'd0, 4'd13, '0, '0, 32'h1234, 32'h5678);
    check("r030_ready", rdy1_o[0], 1);
    step(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, '0, '0, '0, '0);
    check("r030_rsp_valid", rv1_o[0], 1);
    check("r030_result", res1_o[0], 32'd0);
    check("r030_status", st1_o[0], 32'd0);
    check("r030_err", err1_o[0], 1);
    check("r030_alu_op", aop[0], 32'd0);
    idle_steps(2);

    // Continuous contention: grants alternate, four cycles apart at ALU_LAT=1.
    for (int k = 0; k < 20; k++) begin
      step(1'b0, 1'b1, 1'b1, 4'd1, 4'd1, $urandom, $urandom, $urandom, $urandom);
      if (rdy0_o[0] || rdy1_o[0]) begin
        gcyc.push_back(cyc - 1);
        gown.push_back(rdy1_o[0] ? 1 : 0);
      end
    end
    check("r029_grants", gcyc.size(), 5);
    for (int k = 1; k < gcyc.size(); k++) begin
      check("r029_gap", gcyc[k] - gcyc[k-1], 4);
      check("r029_alternate", gown[k], gown[k-1] ^ 1);
    end
    idle_steps(6);

    // Reset while executing: no response, idle next cycle, req0 wins the tie.
    step(1'b0, 1'b0, 1'b1, 4'd0, 4'd1, '0, '0, 32'd7, 32'd8);
    step(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, '0, '0, '0, '0);
    step(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, '0, '0, '0, '0);
    for (int i = 0; i < 3; i++) begin
      check("r031_busy", busy_o[i], 0);
      check("r031_no_rsp", rv1_o[i], 0);
    end
    step(1'b0, 1'b1, 1'b1, 4'd1, 4'd1, 32'd1, 32'd2, 32'd3, 32'd4);
    for (int i = 0; i < 3; i++) check("r031_tie_req0", rdy0_o[i], 1);
    idle_steps(6);

    // Randomized traffic, including occasional resets and withdrawn valids.
    for (int k = 0; k < 1500; k++) begin
      step(($urandom_range(0, 99) == 0),
           ($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 6),
           rand_op(), rand_op(), $urandom, $urandom, $urandom, $urandom);
    end
    idle_steps(6);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
